combo_lock_param: RTL
=====================

COMBO_LOCK_PARAM -- requirements
Module: combo_lock_param

Interface
REQ-001 The block SHALL have parameter DIGIT_W, default 4, meaning bits per code digit.
REQ-002 The block SHALL have parameter CODE_LEN, default 6, meaning digits per code (>=1).
REQ-003 The block SHALL have parameter DEFAULT_CODE, default 24'h654321, meaning the reset code; digit k occupies bits [k*DIGIT_W +: DIGIT_W], digit 0 is entered first.
REQ-004 The block SHALL have parameter MAX_FAIL, default 3, meaning consecutive failed attempts before lockout (>=1).
REQ-005 The block SHALL have parameter LOCKOUT_CYC, default 16, meaning lockout duration in clk cycles (>=1).
REQ-006 clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-007 reset_n  input  1  meaning asynchronous, active-low reset.
REQ-008 digit_in  input  DIGIT_W  meaning the digit sampled on enter.
REQ-009 enter  input  1  meaning the digit-accept strobe; each cycle it is high counts as one event.
REQ-010 prog_en  input  1  meaning the request for program mode, sampled with enter in OPEN.
REQ-011 clear  input  1  meaning abort the current entry sequence.
REQ-012 state  output  3  meaning the FSM state: LOCKED=0, OPEN=1, ERROR=2, LOCKOUT=3, PROG=4.
REQ-013 is_open  output  1  meaning high iff state==OPEN.
REQ-014 digit_cnt  output  IDX_W=$clog2(CODE_LEN+1)  meaning digits accepted in the current sequence.
REQ-015 fail_cnt  output  FW=$clog2(MAX_FAIL+1)  meaning consecutive failed attempts.

Function
REQ-016 In LOCKED, each enter SHALL compare digit_in with stored digit[digit_cnt], OR a mismatch into a sticky miss flag, and increment digit_cnt.
REQ-017 On the CODE_LEN-th enter in LOCKED, the next state SHALL be OPEN if miss and the current compare are both clear, otherwise ERROR; digit_cnt and miss SHALL return to 0.
REQ-018 Success SHALL clear fail_cnt; failure SHALL increment fail_cnt, saturating at MAX_FAIL.
REQ-019 A failure that brings fail_cnt to MAX_FAIL SHALL enter LOCKOUT directly instead of ERROR, loading a lockout counter with LOCKOUT_CYC-1.
REQ-020 In LOCKOUT, the counter SHALL decrement once per cycle, and enter and clear SHALL be ignored; when the counter is 0, the next state SHALL be LOCKED with fail_cnt=0, so LOCKOUT lasts exactly LOCKOUT_CYC cycles.
REQ-021 In ERROR, an enter SHALL return the FSM to LOCKED; the digit presented with that enter SHALL be discarded and not counted.
REQ-022 In OPEN, enter with prog_en=1 SHALL go to PROG with digit_cnt=0; enter with prog_en=0 SHALL go to LOCKED (relock).
REQ-023 In PROG, each enter SHALL write digit_in into a shadow register at index digit_cnt; on the CODE_LEN-th enter the shadow SHALL be committed to the stored code in the same edge, and the next state SHALL be LOCKED with digit_cnt=0.
REQ-024 clear in LOCKED or PROG SHALL zero digit_cnt and miss; PROG+clear SHALL return to OPEN with the stored code unchanged; clear in OPEN or ERROR SHALL have no effect.
REQ-025 clear and enter in the same cycle: clear SHALL win and the digit SHALL be discarded.
REQ-026 Outputs SHALL be registered or decoded from registers only, with no combinational path from inputs to outputs.
REQ-027 Unused state encodings SHALL transition to LOCKED on the next edge.

Reset
REQ-028 When reset_n=0, the block SHALL asynchronously force state=LOCKED, is_open=0, digit_cnt=0, fail_cnt=0, miss=0, lockout counter=0, and stored code=DEFAULT_CODE.
REQ-029 Reset asserted mid-sequence, in PROG, or in LOCKOUT SHALL discard all progress; an uncommitted PROG shadow SHALL NOT reach the stored code.
REQ-030 Reset deassertion SHALL take effect at the next rising clk edge with no extra latency.

Verification
REQ-031 Defaults, reset, then enter digits 1,2,3,4,5,6 -> digit_cnt steps 1..5 then 0, state=OPEN, is_open=1, fail_cnt=0.
REQ-032 Enter 1,2,9,4,5,6 -> no early abort, digit_cnt reaches 5, then state=ERROR, fail_cnt=1; the next enter -> LOCKED, digit_cnt=0.
REQ-033 Three wrong 6-digit sequences -> after the third, state=LOCKOUT for exactly 16 cycles, enters ignored, then LOCKED with fail_cnt=0.
REQ-034 From OPEN, enter with prog_en=1, program 7,7,7,7,7,7 -> LOCKED; entering 1..6 -> ERROR; entering 7x6 -> OPEN.
REQ-035 In PROG after 3 digits, assert clear together with enter -> OPEN, old code 1..6 still opens the lock; repeat with reset_n pulsed instead -> LOCKED, code=DEFAULT_CODE.
REQ-036 Pulse reset_n low between clock edges mid-sequence -> outputs reach reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/combo_lock_param.sv
// Parameterised combination lock: digit-serial entry, fail counting with timed lockout,
// and in-place reprogramming of the stored code from the OPEN state.
module combo_lock_param #(
    parameter int DIGIT_W = 4,
    parameter int CODE_LEN = 6,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 24'h654321,
    parameter int MAX_FAIL = 3,
    parameter int LOCKOUT_CYC = 16,
    localparam int IDX_W = $clog2(CODE_LEN + 1),
    localparam int FW = $clog2(MAX_FAIL + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               enter,
    input  logic               prog_en,
    input  logic               clear,
    output logic [2:0]         state,
    output logic               is_open,
    output logic [IDX_W-1:0]   digit_cnt,
    output logic [FW-1:0]      fail_cnt
);

    // state      | meaning
    // LOCKED  0  | collecting digits of an unlock attempt
    // OPEN    1  | unlocked; enter relocks or (with prog_en) starts programming
    // ERROR   2  | attempt failed; next enter returns to LOCKED, digit discarded
    // LOCKOUT 3  | too many failures; inputs ignored for LOCKOUT_CYC cycles
    // PROG    4  | collecting a new code into the shadow register
    typedef enum logic [2:0] {
        ST_LOCKED  = 3'd0,
        ST_OPEN    = 3'd1,
        ST_ERROR   = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_PROG    = 3'd4
    } state_t;

    localparam int CIW = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int LCW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

    state_t                             state_q, state_d;
    logic [IDX_W-1:0]                   digit_cnt_q, digit_cnt_d;
    logic                               miss_q, miss_d;
    logic [FW-1:0]                      fail_cnt_q, fail_cnt_d;
    logic [LCW-1:0]                     lock_cnt_q, lock_cnt_d;
    logic [CODE_LEN-1:0][DIGIT_W-1:0]   code_q, code_d;
    logic [CODE_LEN-1:0][DIGIT_W-1:0]   shadow_q, shadow_d;

    logic [CIW-1:0] cur_idx;
    logic           mismatch;
    logic           last_digit;
    logic [FW-1:0]  fail_inc;

    assign cur_idx    = CIW'(digit_cnt_q);
    assign mismatch   = (digit_in != code_q[cur_idx]);
    assign last_digit = (digit_cnt_q == IDX_W'(CODE_LEN - 1));
    assign fail_inc   = (fail_cnt_q >= FW'(MAX_FAIL)) ? FW'(MAX_FAIL) : fail_cnt_q + FW'(1);

    always_comb begin
        state_d     = state_q;
        digit_cnt_d = digit_cnt_q;
        miss_d      = miss_q;
        fail_cnt_d  = fail_cnt_q;
        lock_cnt_d  = lock_cnt_q;
        code_d      = code_q;
        shadow_d    = shadow_q;

        case (state_q)
            ST_LOCKED: begin
                if (clear) begin
                    digit_cnt_d = '0;
                    miss_d      = 1'b0;
                end else if (enter) begin
                    if (last_digit) begin
                        digit_cnt_d = '0;
                        miss_d      = 1'b0;
                        if (!miss_q && !mismatch) begin
                            state_d    = ST_OPEN;
                            fail_cnt_d = '0;
                        end else if (fail_inc == FW'(MAX_FAIL)) begin
                            state_d    = ST_LOCKOUT;
                            fail_cnt_d = fail_inc;
                            lock_cnt_d = LCW'(LOCKOUT_CYC - 1);
                        end else begin
                            state_d    = ST_ERROR;
                            fail_cnt_d = fail_inc;
                        end
                    end else begin
                        digit_cnt_d = digit_cnt_q + IDX_W'(1);
                        miss_d      = miss_q | mismatch;
                    end
                end
            end
            // clear does nothing here except suppress a simultaneous enter
            ST_OPEN: begin
                if (enter && !clear) begin
                    digit_cnt_d = '0;
                    state_d     = prog_en ? ST_PROG : ST_LOCKED;
                end
            end
            ST_ERROR: begin
                if (enter && !clear) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (lock_cnt_q == '0) begin
                    state_d    = ST_LOCKED;
                    fail_cnt_d = '0;
                end else begin
                    lock_cnt_d = lock_cnt_q - LCW'(1);
                end
            end
            ST_PROG: begin
                if (clear) begin
                    state_d     = ST_OPEN;
                    digit_cnt_d = '0;
                    miss_d      = 1'b0;
                end else if (enter) begin
                    shadow_d[cur_idx] = digit_in;
                    if (last_digit) begin
                        // commit includes the digit written on this same edge
                        code_d      = shadow_d;
                        state_d     = ST_LOCKED;
                        digit_cnt_d = '0;
                    end else begin
                        digit_cnt_d = digit_cnt_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d     = ST_LOCKED;
                digit_cnt_d = '0;
                miss_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_LOCKED;
            digit_cnt_q <= '0;
            miss_q      <= 1'b0;
            fail_cnt_q  <= '0;
            lock_cnt_q  <= '0;
            code_q      <= DEFAULT_CODE;
            shadow_q    <= '0;
        end else begin
            state_q     <= state_d;
            digit_cnt_q <= digit_cnt_d;
            miss_q      <= miss_d;
            fail_cnt_q  <= fail_cnt_d;
            lock_cnt_q  <= lock_cnt_d;
            code_q      <= code_d;
            shadow_q    <= shadow_d;
        end
    end

    assign state     = state_q;
    assign is_open   = (state_q == ST_OPEN);
    assign digit_cnt = digit_cnt_q;
    assign fail_cnt  = fail_cnt_q;

endmodule
